matrix_loader: RTL and testbench
================================

# matrix_loader

Upstream feeder for `matrix_multiplier`. It accepts a serial stream of `DATA_WIDTH`-bit elements over a valid/ready handshake. It assembles the elements into the packed operand matrices `a` (ROWS_A×COLS_A) and `b` (COLS_A×COLS_B). Each complete operand pair is presented on registered outputs that wire directly to the multiplier's `a`/`b` ports, with an `out_valid`/`out_ready` handshake toward the downstream control.

## Interface
- `DATA_WIDTH`, 8: element width in bits.
- `ROWS_A`, 2: rows of `a`.
- `COLS_A`, 2: columns of `a`, which equal the rows of `b`.
- `COLS_B`, 2: columns of `b`.
- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `in_data`  in  DATA_WIDTH: stream element.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: loader can take an element.
- `in_flush`  in  1: synchronous flush; discards the partially loaded pair.
- `a`  out  [ROWS_A-1:0][COLS_A-1:0][DATA_WIDTH-1:0]: operand A, held while `out_valid`.
- `b`  out  [COLS_A-1:0][COLS_B-1:0][DATA_WIDTH-1:0]: operand B, held while `out_valid`.
- `out_valid`  out  1: `a`/`b` hold a complete pair.
- `out_ready`  in  1: consumer takes the pair.

## Operation
- Definitions:
  - NA = ROWS_A*COLS_A, NB = COLS_A*COLS_B, N = NA+NB.
  - Element index `idx` has width $clog2(N).
- An element is accepted when `in_valid && in_ready` at a rising edge.
- Stream order:
  - First NA elements go to `a`, row-major: `a[r][c]` receives index r*COLS_A+c.
  - Next NB elements go to `b`, row-major: `b[r][c]` receives index NA+r*COLS_B+c.
- The state machine (single-buffer build) has three states:
  - LOAD_A: accept into `a`. On acceptance of index NA-1, go to LOAD_B.
  - LOAD_B: accept into `b`. On acceptance of index N-1, go to HOLD, set `out_valid`, and clear `idx` to 0.
  - HOLD: `in_ready`=0. On `out_valid && out_ready`, clear `out_valid` and go to LOAD_A.
- `in_ready` = (state != HOLD), decoded combinationally from state.
- Index arithmetic: `idx` increments by 1 per accepted element and wraps to 0 after N-1. No other wrap exists.
- `in_flush`:
  - In LOAD_A or LOAD_B: go to LOAD_A with `idx`=0 next cycle, and accept no element that cycle.
  - In HOLD: ignored. The held pair is never discarded by flush.
- Element registers are never cleared between pairs; every one is overwritten before the next `out_valid`.
- Reset values: state LOAD_A, `idx` 0, `a` all 0, `b` all 0, `out_valid` 0, and therefore `in_ready` 1.
- Reset mid-load: everything returns to the reset values immediately and asynchronously. No partial pair survives.

## Timing
- Latency: `out_valid` rises on the edge that accepts element N-1, so it is visible the following cycle. `a`/`b` are fully updated in that same cycle.
- `a`/`b`/`out_valid` are stable while `out_valid && !out_ready`.
- Single-buffer throughput:
  - `in_ready` returns to 1 in the cycle after acceptance.
  - Minimum period is N+1 cycles per pair.
- Simultaneous `in_flush` and `in_valid` in a load state: the flush wins and the element is dropped. `in_ready` stays 1, and the upstream must treat the dropped element as discarded.

## Configuration
- `MATRIX_LOADER_DBUF_EN` defined: double buffering is enabled.
  - A back bank loads while the front bank is presented.
  - `in_ready` = !back_full.
  - When the back bank completes, it is copied to the front on the first edge where the front is empty or is being accepted (`out_valid && out_ready`). This allows `out_valid` to stay high with new data back-to-back, giving a throughput of N cycles per pair.
  - `in_flush` clears only the back bank's `idx`. It never affects the front bank.
- `MATRIX_LOADER_DBUF_EN` undefined: the single-buffer FSM above applies and the design has no second bank registers.

## Structure
- `matrix_pkg` holds:
  - the defaults for DATA_WIDTH, ROWS_A, COLS_A and COLS_B;
  - `typedef enum logic [1:0] {LOAD_A, LOAD_B, HOLD} loader_state_t`;
  - the element-count function returning N.
- One sub-module, `matrix_bank`: one operand-pair register set.
  - Inputs: write enable and `idx`; it decodes the target element.
  - Instantiated once, or twice under `MATRIX_LOADER_DBUF_EN`.

## Test plan
- Reset, then stream 1..8 with `out_ready`=1 and 2×2×2 defaults. Required response:
  - `out_valid` is visible the cycle after element 8 is accepted.
  - `a[0][0]`=1, `a[0][1]`=2, `a[1][0]`=3, `a[1][1]`=4.
  - `b[0][0]`=5, `b[0][1]`=6, `b[1][0]`=7, `b[1][1]`=8.
  - `out_valid` drops after one cycle.
- Same stream with `out_ready`=0 for 5 cycles: `a`/`b`/`out_valid` are held constant and `in_ready`=0 throughout. The pair is accepted when `out_ready`=1.
- Stream 1..3, pulse `in_flush`, then stream 9..16: the output shows a={9,10,11,12} and b={13,14,15,16}.
- Assert `rst_n`=0 after 5 elements: all outputs go to 0 immediately and `in_ready`=1. Streaming 1..8 afterwards yields the correct pair.
- With `in_valid` toggling randomly, stream 3 pairs: each pair matches its row-major order. Without `MATRIX_LOADER_DBUF_EN`, the period is ≥9 cycles.
- With `MATRIX_LOADER_DBUF_EN`, stream 3 pairs continuously with `out_ready`=1: `out_valid` presents each new pair every 8 cycles with no gaps after the first, and `in_ready` never drops.

Source files
------------

// File: rtl/matrix_pkg.sv
// Purpose: shared defaults, loader state encoding and operand element-count helper.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package matrix_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ROWS_A     = 2;
    localparam int DEF_COLS_A     = 2;
    localparam int DEF_COLS_B     = 2;

    typedef enum logic [1:0] {LOAD_A, LOAD_B, HOLD} loader_state_t;

    // Total elements in one operand pair: |a| + |b|.
    function automatic int elem_count(input int rows_a, input int cols_a, input int cols_b);
        return rows_a * cols_a + cols_a * cols_b;
    endfunction

endpackage

// File: rtl/matrix_loader_if.sv
// Purpose: stream-in / operand-pair-out bundle for the matrix loader.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready on the element stream, out_valid/out_ready on the pair.
// Modports: master = stream source and pair consumer, slave = the loader.
interface matrix_loader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS_A     = 2,
    parameter int COLS_A     = 2,
    parameter int COLS_B     = 2
);
    logic [DATA_WIDTH-1:0]                         in_data;
    logic                                          in_valid;
    logic                                          in_ready;
    logic                                          in_flush;
    logic [ROWS_A-1:0][COLS_A-1:0][DATA_WIDTH-1:0] a;
    logic [COLS_A-1:0][COLS_B-1:0][DATA_WIDTH-1:0] b;
    logic                                          out_valid;
    logic                                          out_ready;

    modport master (
        output in_data, in_valid, in_flush, out_ready,
        input  in_ready, a, b, out_valid
    );

    modport slave (
        input  in_data, in_valid, in_flush, out_ready,
        output in_ready, a, b, out_valid
    );
endinterface

// File: rtl/matrix_bank.sv
// Purpose: one operand-pair register set; element write decoded from idx, or whole-pair parallel load.
// Latency: 1 cycle from we/ld to updated a/b.
// Backpressure: none; the owner decides when to write.
// Ports: clk, rst_n, we/idx/din (single element), ld/ld_a/ld_b (whole pair), a/b (contents).
module matrix_bank
    import matrix_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ROWS_A     = DEF_ROWS_A,
    parameter int COLS_A     = DEF_COLS_A,
    parameter int COLS_B     = DEF_COLS_B,
    parameter int IDXW       = $clog2(elem_count(ROWS_A, COLS_A, COLS_B))
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          we,
    input  logic [IDXW-1:0]                               idx,
    input  logic [DATA_WIDTH-1:0]                         din,
    input  logic                                          ld,
    input  logic [ROWS_A-1:0][COLS_A-1:0][DATA_WIDTH-1:0] ld_a,
    input  logic [COLS_A-1:0][COLS_B-1:0][DATA_WIDTH-1:0] ld_b,
    output logic [ROWS_A-1:0][COLS_A-1:0][DATA_WIDTH-1:0] a,
    output logic [COLS_A-1:0][COLS_B-1:0][DATA_WIDTH-1:0] b
);
    localparam int NA = ROWS_A * COLS_A;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a <= '0;
            b <= '0;
        end else if (ld) begin
            a <= ld_a;
            b <= ld_b;
        end else if (we) begin
            // Row-major stream order: all of a first, then all of b.
            for (int r = 0; r < ROWS_A; r++)
                for (int c = 0; c < COLS_A; c++)
                    if (idx == IDXW'(r * COLS_A + c)) a[r][c] <= din;
            for (int r = 0; r < COLS_A; r++)
                for (int c = 0; c < COLS_B; c++)
                    if (idx == IDXW'(NA + r * COLS_B + c)) b[r][c] <= din;
        end
    end
endmodule

// File: rtl/matrix_loader.sv
// Purpose: assembles a serial element stream into operand matrices a/b for the multiplier.
// Latency: out_valid visible the cycle after the last element is accepted (one more with double buffering).
// Backpressure: in_ready low while a complete pair waits for out_ready; flush drops the partial pair.
// Ports: clk, rst_n (async active-low), bus (matrix_loader_if.slave).
// Option: MATRIX_LOADER_DBUF_EN adds a back bank so loading overlaps presentation.
module matrix_loader
    import matrix_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ROWS_A     = DEF_ROWS_A,
    parameter int COLS_A     = DEF_COLS_A,
    parameter int COLS_B     = DEF_COLS_B
) (
    input  logic            clk,
    input  logic            rst_n,
    matrix_loader_if.slave  bus
);
    localparam int NA   = ROWS_A * COLS_A;
    localparam int N    = elem_count(ROWS_A, COLS_A, COLS_B);
    localparam int IDXW = $clog2(N);

    typedef logic [ROWS_A-1:0][COLS_A-1:0][DATA_WIDTH-1:0] a_t;
    typedef logic [COLS_A-1:0][COLS_B-1:0][DATA_WIDTH-1:0] b_t;

    loader_state_t   state, state_n;
    logic [IDXW-1:0] idx, idx_n;
    logic            out_valid, out_valid_n;
    logic            in_ready, acc, we;
    a_t              a_q;
    b_t              b_q;

`ifdef MATRIX_LOADER_DBUF_EN
    // HOLD here means "back bank full". It drains into the front bank on any edge
    // where the front is empty or being consumed; that same edge may already take
    // element 0 of the next pair, so in_ready never dips under steady out_ready.
    logic drain, ld;
    a_t   back_a;
    b_t   back_b;
    assign drain    = (state == HOLD) && (!out_valid || bus.out_ready);
    assign in_ready = (state != HOLD) || drain;
`else
    assign in_ready = (state != HOLD);
`endif

    // Flush wins over a simultaneous element; that element is dropped.
    assign acc = bus.in_valid && in_ready && !bus.in_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD_A;
            idx       <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            out_valid <= out_valid_n;
        end
    end

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        out_valid_n = out_valid;
        we          = 1'b0;
`ifdef MATRIX_LOADER_DBUF_EN
        ld = 1'b0;
        if (out_valid && bus.out_ready) out_valid_n = 1'b0;
        if (drain) begin
            ld          = 1'b1;
            out_valid_n = 1'b1;
            state_n     = LOAD_A;
        end
`else
        if (state == HOLD && out_valid && bus.out_ready) begin
            out_valid_n = 1'b0;
            state_n     = LOAD_A;
        end
`endif
        // A held pair is never discarded, so flush only acts while loading.
        if (bus.in_flush && state != HOLD) begin
            state_n = LOAD_A;
            idx_n   = '0;
        end else if (acc) begin
            we = 1'b1;
            if (idx == IDXW'(N - 1)) begin
                idx_n   = '0;
                state_n = HOLD;
`ifndef MATRIX_LOADER_DBUF_EN
                out_valid_n = 1'b1;
`endif
            end else begin
                idx_n = idx + IDXW'(1);
                if (idx == IDXW'(NA - 1)) state_n = LOAD_B;
            end
        end
    end

`ifdef MATRIX_LOADER_DBUF_EN
    matrix_bank #(.DATA_WIDTH(DATA_WIDTH), .ROWS_A(ROWS_A), .COLS_A(COLS_A), .COLS_B(COLS_B), .IDXW(IDXW)) u_back (
        .clk(clk), .rst_n(rst_n), .we(we), .idx(idx), .din(bus.in_data),
        .ld(1'b0), .ld_a('0), .ld_b('0), .a(back_a), .b(back_b)
    );
    matrix_bank #(.DATA_WIDTH(DATA_WIDTH), .ROWS_A(ROWS_A), .COLS_A(COLS_A), .COLS_B(COLS_B), .IDXW(IDXW)) u_front (
        .clk(clk), .rst_n(rst_n), .we(1'b0), .idx('0), .din('0),
        .ld(ld), .ld_a(back_a), .ld_b(back_b), .a(a_q), .b(b_q)
    );
`else
    matrix_bank #(.DATA_WIDTH(DATA_WIDTH), .ROWS_A(ROWS_A), .COLS_A(COLS_A), .COLS_B(COLS_B), .IDXW(IDXW)) u_bank (
        .clk(clk), .rst_n(rst_n), .we(we), .idx(idx), .din(bus.in_data),
        .ld(1'b0), .ld_a('0), .ld_b('0), .a(a_q), .b(b_q)
    );
`endif

    assign bus.a         = a_q;
    assign bus.b         = b_q;
    assign bus.out_valid = out_valid;
    assign bus.in_ready  = in_ready;
endmodule

// File: tb/tb_matrix_loader.sv
// Purpose: self-checking bench for matrix_loader (2x2x2, 8-bit) with a pair scoreboard.
// Latency: n/a (testbench).
// Backpressure: exercises out_ready stalls, flush, async reset and random in_valid gaps.
module tb_matrix_loader;
    import matrix_pkg::*;

    typedef logic [1:0][1:0][7:0] a_t;
    typedef logic [1:0][1:0][7:0] b_t;
    typedef struct { logic [7:0][7:0] el; bit rnd; a_t exp_a; b_t exp_b; } vec_t;
    typedef struct { a_t a; b_t b; } pair_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    matrix_loader_if #(.DATA_WIDTH(8), .ROWS_A(2), .COLS_A(2), .COLS_B(2)) bus ();
    matrix_loader #(.DATA_WIDTH(8), .ROWS_A(2), .COLS_A(2), .COLS_B(2)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    pair_t sb[$];
    int    pop_cyc[$];
    bit    rand_valid  = 0;
    bit    watch_rdy   = 0;
    bit    rdy_dropped = 0;
    vec_t  vt[4];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Scoreboard: a pair is consumed when out_valid && out_ready at the coming edge.
    initial forever begin
        pair_t e;
        @(negedge clk);
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pair: got a=%0h b=%0h, expected no pair", bus.a, bus.b);
            end else begin
                e = sb.pop_front();
                check("pair_a", bus.a, e.a);
                check("pair_b", bus.b, e.b);
                pop_cyc.push_back(cyc);
            end
        end
        if (watch_rdy && !bus.in_ready) rdy_dropped = 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic push_exp(input a_t ea, input b_t eb);
        pair_t p;
        p.a = ea;
        p.b = eb;
        sb.push_back(p);
    endtask

    // Called #1 after an edge; returns #1 after the edge that accepted d.
    task automatic send(input logic [7:0] d);
        bit done = 0;
        if (rand_valid)
            while ($urandom_range(0, 2) == 0) begin
                bus.in_valid = 1'b0;
                @(posedge clk); #1;
            end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (int g = 0; g < 100 && !done; g++) begin
            done = bus.in_ready;
            @(posedge clk); #1;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready was 0, required 1 within 100 cycles");
        end
    endtask

    task automatic send_pair(input logic [7:0][7:0] el);
        for (int i = 0; i < 8; i++) send(el[i]);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int g = 0; g < 200 && sb.size() != 0; g++) begin
            @(posedge clk); #1;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d pairs outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_ov();
        bit seen = 0;
        for (int g = 0; g < 30 && !seen; g++) begin
            if (bus.out_valid) seen = 1;
            else begin @(posedge clk); #1; end
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL ov_timeout: out_valid was 0, required 1 within 30 cycles");
        end
    endtask

    initial begin
        logic [7:0][7:0] el;
        a_t ea;
        b_t eb;

        vt[0].el = {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        vt[0].rnd = 0; vt[0].exp_a = {8'd4, 8'd3, 8'd2, 8'd1}; vt[0].exp_b = {8'd8, 8'd7, 8'd6, 8'd5};
        vt[1].el = {8'hFE, 8'h01, 8'h7F, 8'h80, 8'h00, 8'hFF, 8'h00, 8'hFF};
        vt[1].rnd = 0; vt[1].exp_a = {8'h00, 8'hFF, 8'h00, 8'hFF}; vt[1].exp_b = {8'hFE, 8'h01, 8'h7F, 8'h80};
        vt[2].el = {8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
        vt[2].rnd = 1; vt[2].exp_a = {8'h44, 8'h33, 8'h22, 8'h11}; vt[2].exp_b = {8'h88, 8'h77, 8'h66, 8'h55};
        vt[3].el = {8'h55, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA};
        vt[3].rnd = 1; vt[3].exp_a = {8'hAA, 8'hAA, 8'hAA, 8'hAA}; vt[3].exp_b = {8'h55, 8'hAA, 8'hAA, 8'hAA};

        bus.in_valid = 0; bus.in_data = '0; bus.in_flush = 0; bus.out_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_a", bus.a, 0);
        check("rst_b", bus.b, 0);
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;

        // Latency: out_valid appears right after the edge taking element 8, for one cycle.
        push_exp(vt[0].exp_a, vt[0].exp_b);
        for (int i = 0; i < 7; i++) send(vt[0].el[i]);
        check("ov_before_last", bus.out_valid, 0);
        send(vt[0].el[7]);
        bus.in_valid = 0;
`ifndef MATRIX_LOADER_DBUF_EN
        check("ov_latency", bus.out_valid, 1);
        check("in_ready_hold", bus.in_ready, 0);
        @(posedge clk); #1;
        check("ov_drop", bus.out_valid, 0);
        check("in_ready_back", bus.in_ready, 1);
`endif
        wait_drain();

        for (int k = 0; k < 4; k++) begin
            rand_valid = vt[k].rnd;
            push_exp(vt[k].exp_a, vt[k].exp_b);
            send_pair(vt[k].el);
            rand_valid = 0;
            wait_drain();
        end

        // Stall: pair must stay put while out_ready is low.
        bus.out_ready = 0;
        push_exp(vt[1].exp_a, vt[1].exp_b);
        send_pair(vt[1].el);
        wait_ov();
        for (int i = 0; i < 5; i++) begin
            check("stall_a", bus.a, vt[1].exp_a);
            check("stall_b", bus.b, vt[1].exp_b);
            check("stall_ov", bus.out_valid, 1);
`ifndef MATRIX_LOADER_DBUF_EN
            check("stall_in_ready", bus.in_ready, 0);
`endif
            @(posedge clk); #1;
        end
        bus.out_ready = 1;
        wait_drain();

        // Flush mid-load, with a simultaneous element that must be dropped.
        push_exp({8'd12, 8'd11, 8'd10, 8'd9}, {8'd16, 8'd15, 8'd14, 8'd13});
        for (int i = 1; i <= 3; i++) send(8'(i));
        bus.in_valid = 1; bus.in_data = 8'd99; bus.in_flush = 1;
        @(posedge clk); #1;
        bus.in_flush = 0; bus.in_valid = 0;
        check("flush_in_ready", bus.in_ready, 1);
        for (int i = 9; i <= 16; i++) send(8'(i));
        bus.in_valid = 0;
        wait_drain();

        // Async reset after 5 elements: clears immediately, no partial pair survives.
        for (int i = 0; i < 5; i++) send(8'(21 + i));
        bus.in_valid = 0;
        #3 rst_n = 0;
        #1;
        check("arst_out_valid", bus.out_valid, 0);
        check("arst_a", bus.a, 0);
        check("arst_b", bus.b, 0);
        check("arst_in_ready", bus.in_ready, 1);
        @(posedge clk);
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
        push_exp(vt[0].exp_a, vt[0].exp_b);
        send_pair(vt[0].el);
        wait_drain();

        // Three pairs with random in_valid gaps.
        pop_cyc.delete();
        rand_valid = 1;
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 8; i++) el[i] = 8'(100 + 8 * p + i);
            for (int r = 0; r < 2; r++)
                for (int c = 0; c < 2; c++) begin
                    ea[r][c] = el[r * 2 + c];
                    eb[r][c] = el[4 + r * 2 + c];
                end
            push_exp(ea, eb);
            send_pair(el);
        end
        rand_valid = 0;
        wait_drain();
        check("rand_pair_count", pop_cyc.size(), 3);
`ifndef MATRIX_LOADER_DBUF_EN
        for (int i = 1; i < pop_cyc.size(); i++)
            check("period_ge_9", (pop_cyc[i] - pop_cyc[i-1]) >= 9, 1);
`else
        // Continuous streaming: one pair every 8 cycles, in_ready never drops.
        pop_cyc.delete();
        watch_rdy = 1;
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 8; i++) el[i] = 8'(200 + 8 * p + i);
            for (int r = 0; r < 2; r++)
                for (int c = 0; c < 2; c++) begin
                    ea[r][c] = el[r * 2 + c];
                    eb[r][c] = el[4 + r * 2 + c];
                end
            push_exp(ea, eb);
            send_pair(el);
        end
        watch_rdy = 0;
        wait_drain();
        check("dbuf_pair_count", pop_cyc.size(), 3);
        for (int i = 1; i < pop_cyc.size(); i++)
            check("dbuf_period_8", pop_cyc[i] - pop_cyc[i-1], 8);
        check("dbuf_in_ready_drop", rdy_dropped, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
